// File: rtl/shared_bus_pkg.sv
// Shared definitions for the shared-bus receive side: default width, destination indices
// and the per-destination slot state.
package shared_bus_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  localparam int unsigned DEST_CEO  = 0;
  localparam int unsigned DEST_YOU  = 1;
  localparam int unsigned DEST_FRED = 2;
  localparam int unsigned DEST_JILL = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// Single-entry valid/ready holding register for one destination of the shared bus.
module demux_slot
  import shared_bus_pkg::*;
#(
  parameter int unsigned Width = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [Width-1:0] wr_data,
  input  logic             ready,
  output logic [Width-1:0] data,
  output logic             valid
);

  slot_state_e      state_q, state_d;
  logic [Width-1:0] data_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (wr) state_d = FULL;
      FULL:  if (ready && !wr) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Contents persist after a drain; consumers qualify with valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (wr) begin
      data_q <= wr_data;
    end
  end

  assign data  = data_q;
  assign valid = (state_q == FULL);

endmodule

// File: rtl/shared_bus_demux.sv
// Receive side of the four-party shared bus: routes tagged words into per-destination slots.
// Optional SHARED_BUS_DEMUX_STATS_EN adds a saturating drop_cnt output.
module shared_bus_demux
  import shared_bus_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             enable,
  output logic [WIDTH-1:0] ceo,
  output logic [WIDTH-1:0] you,
  output logic [WIDTH-1:0] fred,
  output logic [WIDTH-1:0] jill,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef SHARED_BUS_DEMUX_STATS_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  logic [WIDTH-1:0] slot_data [4];
  logic [3:0]       slot_wr;

  // out_ready feeds in_ready combinationally so a draining slot can refill every cycle.
  always_comb begin
    in_ready = 1'b1;
    if (enable) begin
      in_ready = !out_valid[in_sel] || out_ready[in_sel];
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_slot
    assign slot_wr[i] = in_valid && in_ready && enable && (in_sel == 2'(i));

    demux_slot #(
      .Width(WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr     (slot_wr[i]),
      .wr_data(in_data),
      .ready  (out_ready[i]),
      .data   (slot_data[i]),
      .valid  (out_valid[i])
    );
  end

  assign ceo  = slot_data[DEST_CEO];
  assign you  = slot_data[DEST_YOU];
  assign fred = slot_data[DEST_FRED];
  assign jill = slot_data[DEST_JILL];

`ifdef SHARED_BUS_DEMUX_STATS_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // in_ready is always high while disabled, so every valid word is a dropped transfer.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_valid && !enable && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_shared_bus_demux.sv
// Self-checking bench for shared_bus_demux: directed table, hand sequences, random vs model.
module tb_shared_bus_demux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic       enable;
  logic [3:0] ceo, you, fred, jill;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
`ifdef SHARED_BUS_DEMUX_STATS_EN
  logic [7:0] drop_cnt;
`endif

  shared_bus_demux #(
    .WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .enable   (enable),
    .ceo      (ceo),
    .you      (you),
    .fred     (fred),
    .jill     (jill),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef SHARED_BUS_DEMUX_STATS_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what each destination currently holds, and the drop total.
  logic       m_valid [4];
  logic [3:0] m_data  [4];
  int         m_drop;

  typedef struct {
    logic       en;
    logic       v;
    logic [1:0] sel;
    logic [3:0] d;
    logic [3:0] ordy;
    logic       exp_ready;
    logic [3:0] exp_ov;
    logic [3:0] exp_reg;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] dut_reg(input logic [1:0] s);
    case (s)
      2'd0: return ceo;
      2'd1: return you;
      2'd2: return fred;
      default: return jill;
    endcase
  endfunction

  function automatic logic [3:0] m_ov();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = m_valid[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = 4'h0;
    end
    m_drop = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_ov()));
    for (int i = 0; i < 4; i++) chk({tag, "_reg"}, 32'(dut_reg(2'(i))), 32'(m_data[i]));
`ifdef SHARED_BUS_DEMUX_STATS_EN
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  // Call just after a falling edge; returns after the next falling edge.
  task automatic drive(input logic en, input logic v, input logic [1:0] sel, input logic [3:0] d,
                       input logic [3:0] ordy, output logic rdy_act);
    logic rdy_exp;
    logic xfer;
    enable    = en;
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
    #1;
    rdy_exp = !en || !m_valid[sel] || ordy[sel];
    rdy_act = in_ready;
    chk("in_ready", 32'(in_ready), 32'(rdy_exp));
    check_state("pre");
    xfer = v && rdy_exp;
    @(posedge clk);
    for (int i = 0; i < 4; i++) if (m_valid[i] && ordy[i]) m_valid[i] = 1'b0;
    if (xfer && en) begin
      m_valid[sel] = 1'b1;
      m_data[sel]  = d;
    end
    if (xfer && !en && m_drop < 255) m_drop++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 4'h0;
    out_ready = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [6];
  logic rdy;
  int   nx;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 2'd2, 4'hA, 4'b0000, 1'b1, 4'b0100, 4'hA};
    tbl[1] = '{1'b1, 1'b1, 2'd0, 4'h3, 4'b0000, 1'b1, 4'b0101, 4'h3};
    tbl[2] = '{1'b1, 1'b1, 2'd0, 4'h5, 4'b0000, 1'b0, 4'b0101, 4'h3};
    tbl[3] = '{1'b1, 1'b1, 2'd0, 4'h5, 4'b0001, 1'b1, 4'b0101, 4'h5};
    tbl[4] = '{1'b0, 1'b1, 2'd3, 4'hF, 4'b0000, 1'b1, 4'b0101, 4'h0};
    tbl[5] = '{1'b1, 1'b0, 2'd2, 4'h0, 4'b0100, 1'b1, 4'b0001, 4'hA};

    do_reset();
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_regs", 32'({ceo, you, fred, jill}), 32'h0);
    @(negedge clk);

    foreach (tbl[k]) begin
      drive(tbl[k].en, tbl[k].v, tbl[k].sel, tbl[k].d, tbl[k].ordy, rdy);
      chk("tbl_ready", 32'(rdy), 32'(tbl[k].exp_ready));
      chk("tbl_out_valid", 32'(out_valid), 32'(tbl[k].exp_ov));
      chk("tbl_reg", 32'(dut_reg(tbl[k].sel)), 32'(tbl[k].exp_reg));
    end
`ifdef SHARED_BUS_DEMUX_STATS_EN
    chk("drop_after_one", 32'(drop_cnt), 32'd1);
`endif

    // Streaming into one destination with a permanently ready consumer.
    nx = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 2'd1, 4'(i + 6), 4'b0010, rdy);
      if (rdy) nx++;
      chk("stream_you", 32'(you), 32'(i + 6));
      chk("stream_valid", 32'(out_valid[1]), 32'd1);
    end
    chk("stream_xfers", 32'(nx), 32'd8);

    // Fill all four, then drain all in one cycle.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 2'(i), 4'(i + 1), 4'b0000, rdy);
    chk("fill_out_valid", 32'(out_valid), 32'hF);
    drive(1'b1, 1'b0, 2'd0, 4'h0, 4'b1111, rdy);
    chk("drain_out_valid", 32'(out_valid), 32'h0);
    chk("drain_regs", 32'({ceo, you, fred, jill}), 32'h1234);

    // Asynchronous reset with full slots takes effect before the next edge.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 2'(i), 4'hC, 4'b0000, rdy);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'h0);
    chk("async_regs", 32'({ceo, you, fred, jill}), 32'h0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Dropped words: counter saturates, slots untouched.
    for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 2'(i), 4'hF, 4'b0000, rdy);
    chk("drop_out_valid", 32'(out_valid), 32'h0);
`ifdef SHARED_BUS_DEMUX_STATS_EN
    chk("drop_saturate", 32'(drop_cnt), 32'd255);
`endif

    // Randomized traffic against the model.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 5) != 0, 1'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), rdy);
    end
    check_state("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
